// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared constants and width helper for the switch debouncer
package switch_pkg;

   localparam int SW_WIDTH                = 18;
   localparam int SW_TICK_DIV_DEFAULT     = 50000;
   localparam int SW_STABLE_TICKS_DEFAULT = 8;

   // Bits needed to hold the values 0..value-1, never less than one bit.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - synchroniser plus tick-sampled debounce filter for one switch bit
module debounce_bit
   import switch_pkg::*;
#(
   parameter int STABLE_TICKS = SW_STABLE_TICKS_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic sw_raw,
   output logic sw_out,
   output logic sw_rise,
   output logic sw_fall
);

   localparam int               CNT_W    = clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchroniser; only sync2 is trusted downstream.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
      end
   end

   // On each tick, count consecutive disagreements and flip the level after enough of them.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         sw_out  <= 1'b0;
         sw_rise <= 1'b0;
         sw_fall <= 1'b0;
      end else begin
         sw_rise <= 1'b0;
         sw_fall <= 1'b0;
         if (tick) begin
            if (sync2 == sw_out) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               cnt     <= '0;
               sw_out  <= sync2;
               sw_rise <= sync2;
               sw_fall <= ~sync2;
            end else begin
               cnt <= cnt + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - debounced switch vector with sample tick and per-bit edge pulses
module switch_debouncer
   import switch_pkg::*;
#(
   parameter int WIDTH        = SW_WIDTH,
   parameter int TICK_DIV     = SW_TICK_DIV_DEFAULT,
   parameter int STABLE_TICKS = SW_STABLE_TICKS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             tick
);

   localparam int                TICK_W    = clog2(TICK_DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

   logic [TICK_W-1:0] tick_cnt;

   // Free-running divider; tick is registered and fires on the wrap, so the first one lands TICK_DIV cycles after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
         tick     <= 1'b1;
      end else begin
         tick_cnt <= tick_cnt + TICK_ONE;
         tick     <= 1'b0;
      end
   end

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
         ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .sw_raw (sw_raw[i]),
            .sw_out (sw_out[i]),
            .sw_rise(sw_rise[i]),
            .sw_fall(sw_fall[i])
         );
      end
   endgenerate

endmodule
